button_conditioner: RTL and testbench



---
 rtl/button_conditioner.sv | 136 +++++++++++++
 tb/tb_button_conditioner.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - synchronise, debounce, strobe and auto-repeat push-buttons
module button_conditioner #(
  parameter int               N_BTN             = 5,
  parameter int               DB_CYCLES         = 1_000_000,
  parameter int               RPT_DELAY_CYCLES  = 50_000_000,
  parameter int               RPT_PERIOD_CYCLES = 10_000_000,
  parameter logic [N_BTN-1:0] REPEAT_MASK       = 5'b00011
) (
  input  logic             CLK100MHZ,
  input  logic             CPU_RESETN,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  localparam int CNT_MAX_A = (DB_CYCLES > RPT_DELAY_CYCLES) ? DB_CYCLES : RPT_DELAY_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > RPT_PERIOD_CYCLES) ? CNT_MAX_A : RPT_PERIOD_CYCLES;
  localparam int CW        = $clog2(CNT_MAX);

  localparam logic [CW-1:0] DB_LAST  = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] DLY_LAST = CW'(RPT_DELAY_CYCLES - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(RPT_PERIOD_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT  = '1;
  localparam logic [CW-1:0] ONE      = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    REPEAT,
    RELEASE_WAIT
  } state_t;

  logic [N_BTN-1:0] sync_meta;
  logic [N_BTN-1:0] s;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sync_meta <= '0;
      s         <= '0;
    end else begin
      sync_meta <= btn_raw;
      s         <= sync_meta;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    state_t        state;
    logic [CW-1:0] cnt;
    logic          level_q;
    logic          press_q;
    logic          release_q;

    // Strobes default low each cycle so every pulse lasts exactly one clock.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
        state     <= IDLE;
        cnt       <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        case (state)
          IDLE: begin
            if (s[i]) begin
              state <= PRESS_WAIT;
              cnt   <= '0;
            end
          end
          PRESS_WAIT: begin
            if (!s[i]) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt == DB_LAST) begin
              state   <= HELD;
              cnt     <= '0;
              level_q <= 1'b1;
              press_q <= 1'b1;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          HELD: begin
            if (!s[i]) begin
              state <= RELEASE_WAIT;
              cnt   <= '0;
            end else if (REPEAT_MASK[i] && cnt == DLY_LAST) begin
              state   <= REPEAT;
              cnt     <= '0;
              press_q <= 1'b1;
            end else if (cnt != CNT_SAT) begin
              cnt <= cnt + ONE;
            end
          end
          REPEAT: begin
            if (!s[i]) begin
              state <= RELEASE_WAIT;
              cnt   <= '0;
            end else if (cnt == PER_LAST) begin
              cnt     <= '0;
              press_q <= 1'b1;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          RELEASE_WAIT: begin
            // A return to 1 restarts the hold, so the repeat delay runs in full again.
            if (s[i]) begin
              state <= HELD;
              cnt   <= '0;
            end else if (cnt == DB_LAST) begin
              state     <= IDLE;
              cnt       <= '0;
              level_q   <= 1'b0;
              release_q <= 1'b1;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed vector bench for button_conditioner
module tb_button_conditioner;

  localparam int N = 5;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] raw   = '0;
  logic [N-1:0] level;
  logic [N-1:0] press;
  logic [N-1:0] rel;

  int errors = 0;
  int checks = 0;

  button_conditioner #(
    .N_BTN            (5),
    .DB_CYCLES        (4),
    .RPT_DELAY_CYCLES (20),
    .RPT_PERIOD_CYCLES(8),
    .REPEAT_MASK      (5'b00011)
  ) dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .btn_raw    (raw),
    .btn_level  (level),
    .btn_press  (press),
    .btn_release(rel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] raw;
    int           n;
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rls;
  } seg_t;

  seg_t segs[$];
  int   ppos[$];
  int   rpos[$];
  int   tcount;
  int   lvl_gap;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic [N-1:0] r, input int n, input logic [N-1:0] l,
                              input logic [N-1:0] p, input logic [N-1:0] q);
    seg_t sg;
    sg.raw = r; sg.n = n; sg.lvl = l; sg.prs = p; sg.rls = q;
    segs.push_back(sg);
  endfunction

  task automatic begin_seq();
    ppos.delete();
    rpos.delete();
    tcount  = 0;
    lvl_gap = 0;
  endtask

  // Index 0 is the first edge that samples the current raw value.
  task automatic run(input int b, input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      step();
      if (press[b]) ppos.push_back(tcount);
      if (rel[b]) rpos.push_back(tcount);
      if (ppos.size() > 0 && !level[b]) lvl_gap++;
      tcount++;
    end
  endtask

  int exp3[6] = '{6, 26, 34, 42, 50, 58};

  initial begin
    // clean press/release on BTNC (no repeat)
    add(5'h10, 6, 5'h00, 5'h00, 5'h00);
    add(5'h10, 1, 5'h10, 5'h10, 5'h00);
    add(5'h10, 23, 5'h10, 5'h00, 5'h00);
    add(5'h00, 6, 5'h10, 5'h00, 5'h00);
    add(5'h00, 1, 5'h00, 5'h00, 5'h10);
    add(5'h00, 3, 5'h00, 5'h00, 5'h00);
    // bounce on BTNU
    add(5'h01, 2, 5'h00, 5'h00, 5'h00);
    add(5'h00, 2, 5'h00, 5'h00, 5'h00);
    add(5'h01, 2, 5'h00, 5'h00, 5'h00);
    add(5'h00, 2, 5'h00, 5'h00, 5'h00);
    add(5'h01, 6, 5'h00, 5'h00, 5'h00);
    add(5'h01, 1, 5'h01, 5'h01, 5'h00);
    add(5'h01, 3, 5'h01, 5'h00, 5'h00);
    add(5'h00, 6, 5'h01, 5'h00, 5'h00);
    add(5'h00, 1, 5'h00, 5'h00, 5'h01);
    add(5'h00, 2, 5'h00, 5'h00, 5'h00);
    // simultaneous press on three buttons
    add(5'h15, 6, 5'h00, 5'h00, 5'h00);
    add(5'h15, 1, 5'h15, 5'h15, 5'h00);
    add(5'h15, 3, 5'h15, 5'h00, 5'h00);
    add(5'h00, 6, 5'h15, 5'h00, 5'h00);
    add(5'h00, 1, 5'h00, 5'h00, 5'h15);
    add(5'h00, 2, 5'h00, 5'h00, 5'h00);

    step(); step(); step();
    check("reset_outputs", 32'({level, press, rel}), 32'h0);
    rst_n = 1'b1;
    step();
    check("post_reset_idle", 32'({level, press, rel}), 32'h0);

    foreach (segs[si]) begin
      for (int c = 0; c < segs[si].n; c++) begin
        raw = segs[si].raw;
        step();
        check($sformatf("seg%0d_cyc%0d", si, c), 32'({level, press, rel}),
              32'({segs[si].lvl, segs[si].prs, segs[si].rls}));
      end
    end

    // auto-repeat on BTND
    begin_seq();
    raw[1] = 1'b1;
    run(1, 60);
    raw[1] = 1'b0;
    run(1, 10);
    check("rpt_press_count", ppos.size(), 6);
    for (int k = 0; k < 6; k++)
      check($sformatf("rpt_press%0d_pos", k), (k < ppos.size()) ? ppos[k] : -1, exp3[k]);
    check("rpt_release_count", rpos.size(), 1);
    check("rpt_release_pos", (rpos.size() > 0) ? rpos[0] : -1, 66);

    // release bounce while held on BTNU
    begin_seq();
    raw[0] = 1'b1;
    run(0, 10);
    raw[0] = 1'b0;
    run(0, 3);
    raw[0] = 1'b1;
    run(0, 28);
    check("rb_press_count", ppos.size(), 2);
    check("rb_press0_pos", (ppos.size() > 0) ? ppos[0] : -1, 6);
    check("rb_repeat_pos", (ppos.size() > 1) ? ppos[1] : -1, 35);
    check("rb_no_release", rpos.size(), 0);
    check("rb_level_steady", lvl_gap, 0);
    raw[0] = 1'b0;
    run(0, 12);
    check("rb_press_total", ppos.size(), 2);
    check("rb_release_pos", (rpos.size() > 0) ? rpos[0] : -1, 47);

    // reset during PRESS_WAIT on BTNL
    begin_seq();
    raw[2] = 1'b1;
    run(2, 4);
    rst_n = 1'b0;
    #1;
    check("rst_pw_immediate", 32'({level, press, rel}), 32'h0);
    step(); step();
    check("rst_pw_held", 32'({level, press, rel}), 32'h0);
    rst_n = 1'b1;
    begin_seq();
    run(2, 12);
    check("rst_pw_press_count", ppos.size(), 1);
    check("rst_pw_press_pos", (ppos.size() > 0) ? ppos[0] : -1, 6);
    raw[2] = 1'b0;
    run(2, 10);
    check("rst_pw_release_pos", (rpos.size() > 0) ? rpos[0] : -1, 18);

    // reset during REPEAT on BTND
    begin_seq();
    raw[1] = 1'b1;
    run(1, 30);
    check("rst_rp_presses", ppos.size(), 2);
    check("rst_rp_level", 32'(level), 32'h02);
    rst_n = 1'b0;
    #1;
    check("rst_rp_immediate", 32'({level, press, rel}), 32'h0);
    step(); step();
    check("rst_rp_held", 32'({level, press, rel}), 32'h0);
    rst_n = 1'b1;
    begin_seq();
    run(1, 12);
    check("rst_rp_press_count", ppos.size(), 1);
    check("rst_rp_press_pos", (ppos.size() > 0) ? ppos[0] : -1, 6);
    check("rst_rp_no_release", rpos.size(), 0);
    raw[1] = 1'b0;
    run(1, 10);
    check("rst_rp_release_count", rpos.size(), 1);
    check("rst_rp_release_pos", (rpos.size() > 0) ? rpos[0] : -1, 18);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
